// File: rtl/logic_healthcare_system_controller_pkg.sv
// Shared severity type and sensor-level constants for the patient-monitoring
// warning controller.
package logic_healthcare_system_controller_pkg;

  typedef logic [2:0] severity_t;

  localparam severity_t WARN_NONE        = 3'd0;
  localparam severity_t WARN_TEMP        = 3'd1;
  localparam severity_t WARN_NERV_MILD   = 3'd2;
  localparam severity_t WARN_BLOOD       = 3'd3;
  localparam severity_t WARN_PRESSURE    = 3'd4;
  localparam severity_t WARN_NERV_MOD    = 3'd5;
  localparam severity_t WARN_FALL        = 3'd6;
  localparam severity_t WARN_NERV_SEVERE = 3'd7;

  localparam logic [1:0] NERV_NONE     = 2'd0;
  localparam logic [1:0] NERV_MILD     = 2'd1;
  localparam logic [1:0] NERV_MODERATE = 2'd2;
  localparam logic [1:0] NERV_SEVERE   = 2'd3;

endpackage

// File: rtl/logic_healthcare_system_controller_abnormality_priority_encoder.sv
// Combinational strict-priority encoder: folds the sensor flags into a single
// candidate severity code, highest-priority match wins.
module abnormality_priority_encoder
  import logic_healthcare_system_controller_pkg::*;
(
  input  logic       presure_abn_i,
  input  logic       blood_abn_i,
  input  logic       fall_i,
  input  logic       temp_abn_i,
  input  logic [1:0] nerv_lvl_i,
  output logic [2:0] cand_o
);

  always_comb begin
    cand_o = WARN_NONE;
    if (nerv_lvl_i == NERV_SEVERE)        cand_o = WARN_NERV_SEVERE;
    else if (fall_i)                      cand_o = WARN_FALL;
    else if (nerv_lvl_i == NERV_MODERATE) cand_o = WARN_NERV_MOD;
    else if (presure_abn_i)               cand_o = WARN_PRESSURE;
    else if (blood_abn_i)                 cand_o = WARN_BLOOD;
    else if (nerv_lvl_i == NERV_MILD)     cand_o = WARN_NERV_MILD;
    else if (temp_abn_i)                  cand_o = WARN_TEMP;
  end

endmodule

// File: rtl/logic_healthcare_system_controller.sv
// Warning severity register: escalates immediately, de-escalates only after a
// lower candidate has persisted for HOLD_CYCLES consecutive clocks.
module logic_healthcare_system_controller
  import logic_healthcare_system_controller_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       presureAbnormality,
  input  logic       bloodAbnormality,
  input  logic       fallDetected,
  input  logic       temperatureAbnormality,
  input  logic [1:0] nervousAbnormality,
  output logic [2:0] abnormaliryWarning
);

  localparam logic [3:0] HOLD_C = 4'(HOLD_CYCLES);

  severity_t  cand;
  severity_t  warn_q, warn_d;
  severity_t  pend_q, pend_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_nxt;

  abnormality_priority_encoder u_enc (
    .presure_abn_i (presureAbnormality),
    .blood_abn_i   (bloodAbnormality),
    .fall_i        (fallDetected),
    .temp_abn_i    (temperatureAbnormality),
    .nerv_lvl_i    (nervousAbnormality),
    .cand_o        (cand)
  );

  always_comb begin
    warn_d  = warn_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    cnt_nxt = cnt_q;
    if (cand > warn_q) begin
      warn_d = cand;
      cnt_d  = 4'd0;
    end else if (cand == warn_q) begin
      cnt_d = 4'd0;
    end else begin
      // A different lower code restarts the hold with that code as the target.
      if (cand != pend_q) begin
        pend_d  = cand;
        cnt_nxt = 4'd1;
      end else if (cnt_q >= HOLD_C) begin
        cnt_nxt = HOLD_C;
      end else begin
        cnt_nxt = cnt_q + 4'd1;
      end
      if (cnt_nxt >= HOLD_C) begin
        warn_d = pend_d;
        cnt_d  = 4'd0;
      end else begin
        cnt_d = cnt_nxt;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      warn_q <= WARN_NONE;
      pend_q <= WARN_NONE;
      cnt_q  <= 4'd0;
    end else begin
      warn_q <= warn_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign abnormaliryWarning = warn_q;

endmodule

// File: tb/tb_logic_healthcare_system_controller.sv
// Directed and randomized bench for the warning controller, checked against a
// history-window reference model.
module tb_logic_healthcare_system_controller;

  localparam int HOLD = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       presureAbnormality, bloodAbnormality, fallDetected, temperatureAbnormality;
  logic [1:0] nervousAbnormality;
  logic [2:0] abnormaliryWarning;

  int tests_run = 0;
  int tests_failed = 0;

  int model_out = 0;
  int hist[$];

  logic_healthcare_system_controller #(.HOLD_CYCLES(HOLD)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .presureAbnormality     (presureAbnormality),
    .bloodAbnormality       (bloodAbnormality),
    .fallDetected           (fallDetected),
    .temperatureAbnormality (temperatureAbnormality),
    .nervousAbnormality     (nervousAbnormality),
    .abnormaliryWarning     (abnormaliryWarning)
  );

  always #5 clock = ~clock;

  function automatic int severity(input logic p, input logic b, input logic f,
                                  input logic t, input logic [1:0] n);
    if (n == 2'd3) return 7;
    if (f)         return 6;
    if (n == 2'd2) return 5;
    if (p)         return 4;
    if (b)         return 3;
    if (n == 2'd1) return 2;
    if (t)         return 1;
    return 0;
  endfunction

  // Output drops to c only when the last HOLD candidates since reset all equal c.
  function automatic void model_edge();
    int  c;
    bit  all_same;
    if (reset) begin
      model_out = 0;
      hist.delete();
      return;
    end
    c = severity(presureAbnormality, bloodAbnormality, fallDetected,
                 temperatureAbnormality, nervousAbnormality);
    hist.push_back(c);
    while (hist.size() > HOLD) void'(hist.pop_front());
    if (c > model_out) begin
      model_out = c;
    end else if (c < model_out && hist.size() == HOLD) begin
      all_same = 1'b1;
      foreach (hist[i]) if (hist[i] != c) all_same = 1'b0;
      if (all_same) model_out = c;
    end
  endfunction

  task automatic check(input string tag, input int expv);
    tests_run++;
    assert (int'(abnormaliryWarning) === expv) else begin
      tests_failed++;
      $error("FAIL %s: got %0d expected %0d", tag, abnormaliryWarning, expv);
    end
  endtask

  task automatic set_in(input logic p, input logic b, input logic f,
                        input logic t, input logic [1:0] n);
    presureAbnormality     = p;
    bloodAbnormality       = b;
    fallDetected           = f;
    temperatureAbnormality = t;
    nervousAbnormality     = n;
  endtask

  // One clock: advance model on the edge, sample #1 later and compare to it.
  task automatic tick(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check(tag, model_out);
  endtask

  task automatic go_idle();
    set_in(0, 0, 0, 0, 2'd0);
    repeat (HOLD) tick("idle_decay");
  endtask

  initial begin
    int codes[7] = '{1, 2, 3, 4, 5, 6, 7};
    reset = 1'b1;
    set_in(0, 0, 0, 0, 2'd0);
    tick("reset0");
    check("reset_const0", 0);
    tick("reset1");
    reset = 1'b0;
    repeat (3) tick("idle");
    check("idle_const", 0);

    set_in(0, 1, 1, 0, 2'd0);
    tick("esc_fall");
    check("esc_fall_const", 6);
    set_in(0, 1, 1, 0, 2'd2);
    tick("esc_add_nerv2");
    check("esc_stay6_const", 6);
    go_idle();
    check("back_idle", 0);

    for (int k = 0; k < 7; k++) begin
      case (k)
        0: set_in(0, 0, 0, 1, 2'd0);
        1: set_in(0, 0, 0, 0, 2'd1);
        2: set_in(0, 1, 0, 0, 2'd0);
        3: set_in(1, 0, 0, 0, 2'd0);
        4: set_in(0, 0, 0, 0, 2'd2);
        5: set_in(0, 0, 1, 0, 2'd0);
        default: set_in(0, 0, 0, 0, 2'd3);
      endcase
      tick("prio");
      check($sformatf("prio_const%0d", k), codes[k]);
      go_idle();
    end

    set_in(0, 0, 1, 0, 2'd0);
    tick("to6");
    set_in(0, 1, 0, 0, 2'd0);
    tick("hold_e1");
    check("hold_e1_const", 6);
    tick("hold_e2");
    check("hold_e2_const", 3);

    set_in(0, 0, 1, 0, 2'd0);
    tick("to6b");
    set_in(0, 1, 0, 0, 2'd0);
    tick("cancel_e1");
    set_in(0, 0, 1, 0, 2'd0);
    tick("cancel_e2");
    check("cancel_const", 6);
    tick("cancel_e3");
    check("cancel_stay", 6);

    set_in(0, 1, 0, 0, 2'd0);
    tick("restart_3");
    check("restart_3_const", 6);
    set_in(0, 0, 0, 1, 2'd0);
    tick("restart_1a");
    check("restart_1a_const", 6);
    tick("restart_1b");
    check("restart_1b_const", 1);

    set_in(0, 0, 0, 0, 2'd3);
    tick("to7");
    check("to7_const", 7);
    reset = 1'b1;
    tick("rst_mid");
    check("rst_mid_const", 0);
    reset = 1'b0;
    tick("rel");
    check("rel_const", 7);

    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      set_in($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 6) == 0, $urandom_range(0, 2) == 0,
             ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0);
      // Sticky stretches make holds actually complete.
      repeat ($urandom_range(1, 3)) tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
